traffic_lights_monitor: RTL
===========================

Name: traffic_lights_monitor

Overview:
- Passive checker at the consuming end of the traffic-light controller's `lights` bus.
- Samples the 6-bit light vector on every clock-enabled cycle and decodes it into per-direction phases.
- Checks each phase against the legal sequence, the conflict rule and the programmed durations.
- Reports the first violation as a sticky fault and publishes phase and timing statistics for board debug and regression benches.

Parameters:
- CNT_W, 8: width of duration counters and the phase counter.
- YELLOW_LEN, 3: required yellow duration in ce samples.
- ALL_RED_MIN, 1: minimum number of all-red samples before either direction turns green.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low (sampled on rising clk; 0 = reset).
- ce  in  1  sample enable; all checking and counting advance only when ce=1.
- lights  in  6  [5:3] NS {red,yellow,green}, [2:0] EW {red,yellow,green}.
- green_time  in  6  required green duration in ce samples, zero-extended to CNT_W.
- fault  out  1  sticky violation flag.
- fault_code  out  3  code of the first violation.
- phase_count  out  CNT_W  completed NS red->green transitions, wraps modulo 2^CNT_W.
- green_meas  out  CNT_W  measured length of the most recently finished green, either direction.

Behaviour:
- Reset (rst=0 at a clk edge):
  - fault=0, fault_code=0, phase_count=0, green_meas=0.
  - All counters cleared; primed=0.
  - Reset mid-operation discards all history.
- Outputs are registered. A violation sampled at edge N is visible after edge N; there are no combinational paths from inputs to outputs.
- Encoding per direction:
  - Legal values are one-hot only: 100=RED, 010=YELLOW, 001=GREEN.
  - Any other value is illegal, code 1.
- Conflict: both directions non-RED in the same sample, code 2.
- Priming: the first ce sample after reset loads the previous-phase registers. No transition or duration check runs on it; encoding and conflict are still checked. primed is set afterwards.
- Legal transitions per direction: GREEN->YELLOW, YELLOW->RED, RED->GREEN, or the phase holds. Any other change is code 3. Transition checks use the previous valid decoded phase.
- Green timing:
  - A per-direction counter counts samples while GREEN and saturates at all-ones.
  - Count exceeding green_time while still GREEN raises code 4 immediately.
  - On GREEN->YELLOW with count < green_time, code 4.
  - On GREEN exit, the count is written to green_meas, regardless of error.
- Yellow timing: the sample count must equal YELLOW_LEN exactly. Longer raises code 5 at the first excess sample; shorter raises code 5 on YELLOW->RED.
- All-red gap:
  - An all-red counter counts consecutive samples with both directions RED. It resets on any non-all-red sample and saturates.
  - RED->GREEN on either direction with all-red count < ALL_RED_MIN raises code 6.
- phase_count increments on each NS RED->GREEN transition, including one that also faults.
- Fault latching:
  - The first violation sets fault=1 and fault_code; later violations do not alter the code.
  - Only reset clears the fault.
  - Monitoring and statistics continue after a fault.
- Simultaneous violations in one sample: the lowest code wins (1 > 2 > 3 > 4 > 5 > 6).
- An illegal-encoding sample does not update that direction's previous phase or counters.
- ce=0: no state changes and no checks; inputs are ignored.
- Code 0 means no fault; code 7 is unused.

Test Plan:
- Nominal cycle, green_time=15, YELLOW_LEN=3, ALL_RED_MIN=1:
  - Sequence: NS G15/Y3/R, 1 all-red, EW G15/Y3/R, 1 all-red, repeat 4 times.
  - Expected: fault=0; green_meas=15 after each green; phase_count=4 (priming NS green uncounted, then 4 red->green).
- Short green:
  - Stimulus: NS green 10 samples then yellow, green_time=15.
  - Expected: fault=1, code=4 one cycle after the yellow sample; green_meas=10.
- Conflict plus illegal encoding in the same sample:
  - Stimulus: lights=6'b011001.
  - Expected: code=1 (priority over 2). A following sample of 6'b001001 keeps code=1.
- Bad transition and all-red gap:
  - Stimulus: NS GREEN->RED directly.
  - Expected: code=3. A separate run with EW RED->GREEN in the same sample NS goes RED gives code=6.
- ce gating and reset:
  - Stimulus: hold ce=0 while lights toggle illegally.
  - Expected: no fault.
  - Then assert rst=0 for one edge mid-green.
  - Expected: all outputs 0 next cycle; the first sample after reset primes without a transition error.
- Saturation and wrap, CNT_W=8:
  - Stimulus: run 256 NS phases.
  - Expected: phase_count wraps to 0.
  - Stimulus: green_time=63 with 300 green samples.
  - Expected: code=4 at sample 64; the counter saturates at 255 without wrap.

Source files
------------

// File: rtl/traffic_lights_monitor_if.sv
// Bus between the traffic-light controller's lights output and its passive monitor.
// The master drives the light samples and configuration, and the slave reports faults and statistics.
interface traffic_lights_monitor_if #(
    parameter int CNT_W = 8
);
    logic             ce;
    logic [5:0]       lights;
    logic [5:0]       green_time;
    logic             fault;
    logic [2:0]       fault_code;
    logic [CNT_W-1:0] phase_count;
    logic [CNT_W-1:0] green_meas;

    modport master (
        output ce, lights, green_time,
        input  fault, fault_code, phase_count, green_meas
    );

    modport slave (
        input  ce, lights, green_time,
        output fault, fault_code, phase_count, green_meas
    );
endinterface

// File: rtl/traffic_lights_monitor.sv
// Passive checker for the NS/EW light vector: encoding, conflict, sequence and timing.
// The first violation is latched as a sticky fault, and statistics keep running afterwards.
module traffic_lights_monitor #(
    parameter int CNT_W       = 8,
    parameter int YELLOW_LEN  = 3,
    parameter int ALL_RED_MIN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_lights_monitor_if.slave bus
);

    typedef enum logic [1:0] {PH_RED, PH_YELLOW, PH_GREEN} phase_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t YEL_LEN_C = cnt_t'(YELLOW_LEN);
    localparam cnt_t AR_MIN_C  = cnt_t'(ALL_RED_MIN);

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

    // Index 0 is NS (lights[5:3]) and index 1 is EW (lights[2:0]).
    phase_t     r_prev [2];
    cnt_t       r_gcnt [2];
    cnt_t       r_ycnt [2];
    cnt_t       r_allred;
    logic       r_primed;
    logic       r_fault;
    logic [2:0] r_code;
    cnt_t       r_phase_count;
    cnt_t       r_green_meas;

    phase_t     w_nxt_prev [2];
    cnt_t       w_nxt_gcnt [2];
    cnt_t       w_nxt_ycnt [2];
    cnt_t       w_nxt_allred;
    cnt_t       w_gt;
    logic [6:1] w_err;
    logic [2:0] w_code;
    logic       w_meas_we;
    cnt_t       w_meas_val;
    logic       w_ns_r2g;
    logic [1:0] w_non_red;

    assign w_gt = cnt_t'(bus.green_time);

    always_comb begin
        logic [2:0] v;
        phase_t     cur;
        phase_t     prev;
        logic       ok;
        // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
        v            = '0;
        cur          = PH_RED;
        prev         = PH_RED;
        ok           = 1'b0;
        w_nxt_prev   = r_prev;
        w_nxt_gcnt   = r_gcnt;
        w_nxt_ycnt   = r_ycnt;
        w_err        = '0;
        w_meas_we    = 1'b0;
        w_meas_val   = r_green_meas;
        w_ns_r2g     = 1'b0;
        w_non_red    = '0;
        w_nxt_allred = (bus.lights == 6'b100100) ? sat_inc(r_allred) : '0;

        for (int d = 0; d < 2; d++) begin
            v            = (d == 0) ? bus.lights[5:3] : bus.lights[2:0];
            w_non_red[d] = (v != 3'b100);
            prev         = r_prev[d];
            case (v)
                3'b100:  begin ok = 1'b1; cur = PH_RED;    end
                3'b010:  begin ok = 1'b1; cur = PH_YELLOW; end
                3'b001:  begin ok = 1'b1; cur = PH_GREEN;  end
                default: begin ok = 1'b0; cur = PH_RED;    end
            endcase

            if (!ok) begin
                w_err[1] = 1'b1;
            end else begin
                w_nxt_prev[d] = cur;
                if (cur == PH_GREEN)
                    w_nxt_gcnt[d] = (prev == PH_GREEN) ? sat_inc(r_gcnt[d]) : cnt_t'(1);
                if (cur == PH_YELLOW)
                    w_nxt_ycnt[d] = (prev == PH_YELLOW) ? sat_inc(r_ycnt[d]) : cnt_t'(1);

                // The priming sample only seeds history; sequence and duration checks need a real predecessor.
                if (r_primed) begin
                    if (cur != prev &&
                        !((prev == PH_GREEN  && cur == PH_YELLOW) ||
                          (prev == PH_YELLOW && cur == PH_RED)    ||
                          (prev == PH_RED    && cur == PH_GREEN)))
                        w_err[3] = 1'b1;
                    if (cur == PH_GREEN && w_nxt_gcnt[d] > w_gt)
                        w_err[4] = 1'b1;
                    if (prev == PH_GREEN && cur != PH_GREEN) begin
                        w_meas_we  = 1'b1;
                        w_meas_val = r_gcnt[d];
                        if (cur == PH_YELLOW && r_gcnt[d] < w_gt)
                            w_err[4] = 1'b1;
                    end
                    if (cur == PH_YELLOW && w_nxt_ycnt[d] > YEL_LEN_C)
                        w_err[5] = 1'b1;
                    if (prev == PH_YELLOW && cur == PH_RED && r_ycnt[d] < YEL_LEN_C)
                        w_err[5] = 1'b1;
                    if (prev == PH_RED && cur == PH_GREEN) begin
                        if (r_allred < AR_MIN_C)
                            w_err[6] = 1'b1;
                        if (d == 0)
                            w_ns_r2g = 1'b1;
                    end
                end
            end
        end

        w_err[2] = w_non_red[0] & w_non_red[1];

        if      (w_err[1]) w_code = 3'd1;
        else if (w_err[2]) w_code = 3'd2;
        else if (w_err[3]) w_code = 3'd3;
        else if (w_err[4]) w_code = 3'd4;
        else if (w_err[5]) w_code = 3'd5;
        else if (w_err[6]) w_code = 3'd6;
        else               w_code = 3'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev        <= '{default: PH_RED};
            r_gcnt        <= '{default: '0};
            r_ycnt        <= '{default: '0};
            r_allred      <= '0;
            r_primed      <= 1'b0;
            r_fault       <= 1'b0;
            r_code        <= '0;
            r_phase_count <= '0;
            r_green_meas  <= '0;
        end else if (bus.ce) begin
            r_prev   <= w_nxt_prev;
            r_gcnt   <= w_nxt_gcnt;
            r_ycnt   <= w_nxt_ycnt;
            r_allred <= w_nxt_allred;
            r_primed <= 1'b1;
            if (!r_fault && w_code != 3'd0) begin
                r_fault <= 1'b1;
                r_code  <= w_code;
            end
            if (w_meas_we)
                r_green_meas <= w_meas_val;
            if (w_ns_r2g)
                r_phase_count <= r_phase_count + cnt_t'(1);
        end
    end

    assign bus.fault       = r_fault;
    assign bus.fault_code  = r_code;
    assign bus.phase_count = r_phase_count;
    assign bus.green_meas  = r_green_meas;

endmodule
